// File: rtl/ibuf_if.sv
// rtl/ibuf_if.sv - fetch/decode side signal bundle of the ibuf instruction buffer
//
// Purpose: groups the fetch push port and decode pop port of ibuf.
//   master: fetch + decode side (drives input_size/in_*/pop_size, samples outputs)
//   slave : the buffer itself
// Signals:
//   ibuf_i_ready               buffer -> fetch, new request may be issued
//   input_size[1:0]            entries offered this cycle (0..2)
//   in_pc0/inst0/pred_*0       slot-0 payload
//   in_pc1/inst1/pred_*1       slot-1 payload
//   in_have_excp/in_excp_type  fetch exception carried by slot 0
//   out_valid0/1, out_*0/1     head / head+1 entries
//   pop_size[1:0]              entries decode consumes this cycle (0..2)
// Exception codes are 6 bits wide.

interface ibuf_if;
  logic        ibuf_i_ready;
  logic [1:0]  input_size;
  logic [31:0] in_pc0;
  logic [31:0] in_inst0;
  logic        in_pred_taken0;
  logic [31:0] in_pred_target0;
  logic [31:0] in_pc1;
  logic [31:0] in_inst1;
  logic        in_pred_taken1;
  logic [31:0] in_pred_target1;
  logic        in_have_excp;
  logic [5:0]  in_excp_type;
  logic        out_valid0;
  logic [31:0] out_pc0;
  logic [31:0] out_inst0;
  logic        out_pred_taken0;
  logic [31:0] out_pred_target0;
  logic        out_have_excp0;
  logic [5:0]  out_excp_type0;
  logic        out_valid1;
  logic [31:0] out_pc1;
  logic [31:0] out_inst1;
  logic        out_pred_taken1;
  logic [31:0] out_pred_target1;
  logic        out_have_excp1;
  logic [5:0]  out_excp_type1;
  logic [1:0]  pop_size;

  modport master (
    input  ibuf_i_ready,
    output input_size, in_pc0, in_inst0, in_pred_taken0, in_pred_target0,
           in_pc1, in_inst1, in_pred_taken1, in_pred_target1,
           in_have_excp, in_excp_type, pop_size,
    input  out_valid0, out_pc0, out_inst0, out_pred_taken0, out_pred_target0,
           out_have_excp0, out_excp_type0,
           out_valid1, out_pc1, out_inst1, out_pred_taken1, out_pred_target1,
           out_have_excp1, out_excp_type1
  );

  modport slave (
    output ibuf_i_ready,
    input  input_size, in_pc0, in_inst0, in_pred_taken0, in_pred_target0,
           in_pc1, in_inst1, in_pred_taken1, in_pred_target1,
           in_have_excp, in_excp_type, pop_size,
    output out_valid0, out_pc0, out_inst0, out_pred_taken0, out_pred_target0,
           out_have_excp0, out_excp_type0,
           out_valid1, out_pc1, out_inst1, out_pred_taken1, out_pred_target1,
           out_have_excp1, out_excp_type1
  );
endinterface

// File: rtl/ibuf.sv
// rtl/ibuf.sv - dual-issue instruction buffer between fetch and decode
//
// Purpose: circular FIFO of DEPTH entries {pc, inst, pred_taken, pred_target,
//   have_excp, excp_type}; accepts 0/1/2 entries per cycle from fetch and
//   presents the two oldest entries to decode, which pops 0/1/2.
// Ports:
//   clk               clock
//   resetn            asynchronous active-low reset
//   flush             synchronous empty (mispredict / exception / replay)
//   bus (slave)       fetch push port, decode pop port, ibuf_i_ready
//   perf_clear        (IBUF_PERF_EN) synchronous zeroing of the perf counters
//   perf_full_cycles  (IBUF_PERF_EN) cycles with ibuf_i_ready low, saturating
//   perf_empty_cycles (IBUF_PERF_EN) cycles with the buffer empty, saturating
// Optional feature macro: IBUF_PERF_EN (undefined: no perf ports or counters).

module ibuf #(
  parameter int DEPTH       = 8,
  parameter int READY_SLACK = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
`ifdef IBUF_PERF_EN
  input  logic        perf_clear,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_empty_cycles,
`endif
  ibuf_if.slave       bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        have_excp;
    logic [5:0]  excp_type;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_p1, tail_p1;
  logic [1:0]      in_sz, pop_sz, pop_lim, pop_eff, push_lim, push_eff;
  logic [CW-1:0]   room;
  logic            ready;
  entry_t          slot0, slot1;

  assign head_p1 = head_q + PW'(1);
  assign tail_p1 = tail_q + PW'(1);

  always_comb begin
    // size 3 is illegal; treat it as 2 so hardware stays within its two write ports
    in_sz  = (bus.input_size == 2'd3) ? 2'd2 : bus.input_size;
    pop_sz = (bus.pop_size == 2'd3) ? 2'd2 : bus.pop_size;

    // underflow: never pop more than is held at the start of the cycle
    pop_lim = (count_q < CW'(2)) ? count_q[1:0] : 2'd2;
    pop_eff = (pop_sz > pop_lim) ? pop_lim : pop_sz;

    // overflow: space freed by this cycle's pop is reusable; excess is dropped
    room     = CW'(DEPTH) - count_q + CW'(pop_eff);
    push_lim = (room < CW'(2)) ? room[1:0] : 2'd2;
    push_eff = (in_sz > push_lim) ? push_lim : in_sz;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_eff);
      tail_d  = tail_q + PW'(push_eff);
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_comb begin
    slot0 = '{pc: bus.in_pc0, inst: bus.in_inst0, pred_taken: bus.in_pred_taken0,
              pred_target: bus.in_pred_target0, have_excp: bus.in_have_excp,
              excp_type: bus.in_excp_type};
    // fetch exceptions only ever travel with slot 0
    slot1 = '{pc: bus.in_pc1, inst: bus.in_inst1, pred_taken: bus.in_pred_taken1,
              pred_target: bus.in_pred_target1, have_excp: 1'b0,
              excp_type: 6'd0};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // flush only rewinds the pointers; stale array contents are unreachable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush) begin
      if (push_eff != 2'd0) mem_q[tail_q]  <= slot0;
      if (push_eff == 2'd2) mem_q[tail_p1] <= slot1;
    end
  end

  assign ready            = (CW'(DEPTH) - count_q) >= CW'(READY_SLACK);
  assign bus.ibuf_i_ready = ready;

  assign bus.out_valid0       = (count_q != '0);
  assign bus.out_pc0          = mem_q[head_q].pc;
  assign bus.out_inst0        = mem_q[head_q].inst;
  assign bus.out_pred_taken0  = mem_q[head_q].pred_taken;
  assign bus.out_pred_target0 = mem_q[head_q].pred_target;
  assign bus.out_have_excp0   = mem_q[head_q].have_excp;
  assign bus.out_excp_type0   = mem_q[head_q].excp_type;

  assign bus.out_valid1       = (count_q >= CW'(2));
  assign bus.out_pc1          = mem_q[head_p1].pc;
  assign bus.out_inst1        = mem_q[head_p1].inst;
  assign bus.out_pred_taken1  = mem_q[head_p1].pred_taken;
  assign bus.out_pred_target1 = mem_q[head_p1].pred_target;
  assign bus.out_have_excp1   = mem_q[head_p1].have_excp;
  assign bus.out_excp_type1   = mem_q[head_p1].excp_type;

`ifdef IBUF_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else if (perf_clear) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (!ready && perf_full_cycles != 32'hFFFF_FFFF)
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if (count_q == '0 && perf_empty_cycles != 32'hFFFF_FFFF)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`endif

  // protocol checks on the fetch/decode side
  assert property (@(posedge clk) disable iff (!resetn || flush)
                   bus.input_size != 2'd3);
  assert property (@(posedge clk) disable iff (!resetn || flush)
                   bus.pop_size != 2'd3);
  assert property (@(posedge clk) disable iff (!resetn || flush)
                   {{(CW-2){1'b0}}, bus.pop_size} <= count_q);
  assert property (@(posedge clk) disable iff (!resetn || flush)
                   {{(CW-2){1'b0}}, bus.input_size} <= room);
  assert property (@(posedge clk) disable iff (!resetn || flush)
                   bus.in_have_excp |-> bus.input_size == 2'd1);

endmodule
